// File: rtl/spike_classifier_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spike_classifier_if                                          |
// | Description : Bundle between the spike source / result reader (master)     |
// |               and the spike classifier (slave).                            |
// |               master drives : START, Spikes_in                             |
// |               slave drives  : Busy, Valid, Result, Max_count, Tie          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spike_classifier_if #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int RES_W       = 4
);
  logic                   START;
  logic [NUM_CLASSES-1:0] Spikes_in;
  logic                   Busy;
  logic                   Valid;
  logic [RES_W-1:0]       Result;
  logic [CNT_WIDTH-1:0]   Max_count;
  logic                   Tie;

  modport master (
    output START, Spikes_in,
    input  Busy, Valid, Result, Max_count, Tie
  );

  modport slave (
    input  START, Spikes_in,
    output Busy, Valid, Result, Max_count, Tie
  );
endinterface
`default_nettype wire

// File: rtl/spike_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spike_classifier                                             |
// | Description : Counts spikes per class over a WINDOW-cycle presentation,    |
// |               then scans the counters one class per cycle to pick the      |
// |               winner (lowest index on ties) and pulses Valid for one cycle.|
// | Ports       : CLK  - system clock, rising edge                             |
// |               RST  - synchronous active-high reset                         |
// |               bus  - spike_classifier_if.slave                             |
// |                      START (in), Spikes_in (in), Busy, Valid, Result,      |
// |                      Max_count, Tie (out)                                  |
// | Config      : SPIKE_CLASSIFIER_TIE_EN - build the tie-flag logic; when     |
// |               undefined Tie is tied to 0.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spike_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int WINDOW      = 1000,
  parameter int CNT_WIDTH   = 8,
  parameter int RES_W       = 4
) (
  input wire                CLK,
  input wire                RST,
  spike_classifier_if.slave bus
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                                  state_q, state_d;
  logic [NUM_CLASSES-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]                        win_q, win_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [CNT_WIDTH-1:0]                    max_q, max_d;
  logic [RES_W-1:0]                        ridx_q, ridx_d;
  logic [RES_W-1:0]                        res_q, res_d;
  logic [CNT_WIDTH-1:0]                    maxc_q, maxc_d;
`ifdef SPIKE_CLASSIFIER_TIE_EN
  logic                                    tie_q, tie_d;
  logic                                    tie_out_q, tie_out_d;
`endif

  logic [CNT_WIDTH-1:0] w_cur;
  logic                 w_start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    idx_d     = idx_q;
    max_d     = max_q;
    ridx_d    = ridx_q;
    res_d     = res_q;
    maxc_d    = maxc_q;
`ifdef SPIKE_CLASSIFIER_TIE_EN
    tie_d     = tie_q;
    tie_out_d = tie_out_q;
`endif
    w_cur     = cnt_q[idx_q];
    w_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          w_start = 1'b1;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        // Saturating per-class counters; the last window cycle still counts.
        for (int k = 0; k < NUM_CLASSES; k++) begin
          if (bus.Spikes_in[k] && (cnt_q[k] != CNT_MAX)) begin
            cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
          end
        end
        win_d = win_q + WIN_W'(1);
        if (win_q == WIN_LAST) begin
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        idx_d = idx_q + IDX_W'(1);
        // Strict compare keeps the earliest index on equal counts.
        if (w_cur > max_q) begin
          max_d  = w_cur;
          ridx_d = RES_W'(idx_q);
`ifdef SPIKE_CLASSIFIER_TIE_EN
          tie_d  = 1'b0;
`endif
        end
`ifdef SPIKE_CLASSIFIER_TIE_EN
        else if ((w_cur == max_q) && (max_q != '0)) begin
          tie_d = 1'b1;
        end
`endif
        // Results are loaded on the way into DONE so they are already
        // visible in the cycle that Valid is high.
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          maxc_d  = max_d;
          if (max_d == '0) begin
            res_d = {RES_W{1'b1}};
`ifdef SPIKE_CLASSIFIER_TIE_EN
            tie_out_d = 1'b0;
`endif
          end else begin
            res_d = ridx_d;
`ifdef SPIKE_CLASSIFIER_TIE_EN
            tie_out_d = tie_d;
`endif
          end
        end
      end

      S_DONE: begin
        if (bus.START) begin
          w_start = 1'b1;
          state_d = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new window starts from clean counters and scan state; the
    // reported outputs are left untouched until the next DONE.
    if (w_start) begin
      cnt_d  = '0;
      win_d  = '0;
      idx_d  = '0;
      max_d  = '0;
      ridx_d = '0;
`ifdef SPIKE_CLASSIFIER_TIE_EN
      tie_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      ridx_q    <= '0;
      res_q     <= '0;
      maxc_q    <= '0;
`ifdef SPIKE_CLASSIFIER_TIE_EN
      tie_q     <= 1'b0;
      tie_out_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      ridx_q    <= ridx_d;
      res_q     <= res_d;
      maxc_q    <= maxc_d;
`ifdef SPIKE_CLASSIFIER_TIE_EN
      tie_q     <= tie_d;
      tie_out_q <= tie_out_d;
`endif
    end
  end

  assign bus.Busy      = (state_q == S_COUNT) || (state_q == S_SCAN);
  assign bus.Valid     = (state_q == S_DONE);
  assign bus.Result    = res_q;
  assign bus.Max_count = maxc_q;
`ifdef SPIKE_CLASSIFIER_TIE_EN
  assign bus.Tie       = tie_out_q;
`else
  assign bus.Tie       = 1'b0;
`endif

endmodule
`default_nettype wire
